// File: rtl/nios_onchip_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : nios_onchip_mem_arbiter_if
// Brief    : Avalon-MM master port bundle (request, stall and read response).
// Revision : 1.0
// ============================================================================
interface nios_onchip_mem_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 128,
  parameter int BE_W   = 16
);
  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface
`default_nettype wire

// File: rtl/nios_onchip_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : nios_onchip_mem_arbiter
// Brief    : Two-master round-robin arbiter for a 1-cycle-latency on-chip RAM.
//            Optional post-reset RAM zeroing: define NIOS_MEM_ARB_CLEAR_EN.
// Revision : 1.0
// ============================================================================
module nios_onchip_mem_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 128,
  parameter int BE_W   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     reset_req,
  nios_onchip_mem_arbiter_if.slave m0,
  nios_onchip_mem_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]        mem_address,
  output logic [BE_W-1:0]          mem_byteenable,
  output logic                     mem_chipselect,
  output logic                     mem_write,
  output logic [DATA_W-1:0]        mem_writedata,
  output logic                     mem_clken,
  input  logic [DATA_W-1:0]        mem_readdata,
  output logic                     init_done
);

  logic w_req0, w_req1, w_rd0, w_rd1;
  logic w_allow, w_gnt0, w_gnt1;
  logic r_last_grant, r_rd_pend, r_rd_tag;
  logic w_clearing;
  logic [ADDR_W-1:0] w_clear_addr;

  // A simultaneous read+write is treated as a write; the read is dropped.
  assign w_req0 = m0.read | m0.write;
  assign w_req1 = m1.read | m1.write;
  assign w_rd0  = m0.read & ~m0.write;
  assign w_rd1  = m1.read & ~m1.write;

  assign w_allow = init_done & ~reset_req & ~reset;
  assign w_gnt0  = w_allow & w_req0 & (~w_req1 | r_last_grant);
  assign w_gnt1  = w_allow & w_req1 & (~w_req0 | ~r_last_grant);

  assign m0.waitrequest = ~w_gnt0 & (w_req0 | ~w_allow);
  assign m1.waitrequest = ~w_gnt1 & (w_req1 | ~w_allow);

  assign mem_clken = ~reset_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= 1'b1;
      r_rd_pend    <= 1'b0;
      r_rd_tag     <= 1'b0;
    end else begin
      if (w_gnt0) begin
        r_last_grant <= 1'b0;
      end else if (w_gnt1) begin
        r_last_grant <= 1'b1;
      end
      r_rd_pend <= (w_gnt0 & w_rd0) | (w_gnt1 & w_rd1);
      if (w_gnt0 | w_gnt1) begin
        r_rd_tag <= w_gnt1;
      end
    end
  end

  // The response is masked while reset is high so an in-flight read is dropped.
  assign m0.readdatavalid = r_rd_pend & ~r_rd_tag & ~reset;
  assign m1.readdatavalid = r_rd_pend &  r_rd_tag & ~reset;
  assign m0.readdata      = mem_readdata;
  assign m1.readdata      = mem_readdata;

`ifdef NIOS_MEM_ARB_CLEAR_EN
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_clr_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_CLEAR;
      r_clr_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_clearing) begin
        r_clr_addr <= r_clr_addr + ADDR_W'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_CLEAR && !reset_req && (&r_clr_addr)) begin
      w_state_nxt = ST_RUN;
    end
  end

  assign w_clearing   = (r_state == ST_CLEAR) & ~reset_req & ~reset;
  assign w_clear_addr = r_clr_addr;
  assign init_done    = (r_state == ST_RUN);
`else
  logic r_init_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_init_done <= 1'b0;
    end else begin
      r_init_done <= 1'b1;
    end
  end

  assign w_clearing   = 1'b0;
  assign w_clear_addr = '0;
  assign init_done    = r_init_done;
`endif

  always_comb begin
    mem_address    = m0.address;
    mem_byteenable = m0.byteenable;
    mem_writedata  = m0.writedata;
    mem_chipselect = w_gnt0 | w_gnt1;
    mem_write      = (w_gnt0 & m0.write) | (w_gnt1 & m1.write);
    if (w_clearing) begin
      mem_address    = w_clear_addr;
      mem_byteenable = '1;
      mem_writedata  = '0;
      mem_chipselect = 1'b1;
      mem_write      = 1'b1;
    end else if (w_gnt1) begin
      mem_address    = m1.address;
      mem_byteenable = m1.byteenable;
      mem_writedata  = m1.writedata;
    end
  end

  // r_rd_pend high means a read was accepted last cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(m0.read && m0.write));
      assert (!(m1.read && m1.write));
      assert (!(reset_req && r_rd_pend));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nios_onchip_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_nios_onchip_mem_arbiter
// Brief    : Self-checking bench with a RAM model and a scoreboard of expected grants.
// Revision : 1.0
// ============================================================================
module tb_nios_onchip_mem_arbiter;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 128;
  localparam int BE_W   = 16;
  localparam int DEPTH  = 2048;
`ifdef NIOS_MEM_ARB_CLEAR_EN
  localparam int INIT_CYCLES = 2048;
`else
  localparam int INIT_CYCLES = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic reset_req = 1'b0;
  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect, mem_write, mem_clken, init_done;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata = '0;

  nios_onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) m0_bus ();
  nios_onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) m1_bus ();

  nios_onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) dut (
    .clk(clk), .reset(reset), .reset_req(reset_req),
    .m0(m0_bus.slave), .m1(m1_bus.slave),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .init_done(init_done)
  );

  always #5 clk = ~clk;

  // Byte-enabled single-port RAM, registered read.
  logic [DATA_W-1:0] ram [DEPTH];
  logic ram_ready = 1'b0;
  always @(posedge clk) begin
    logic [DATA_W-1:0] merged;
    if (!ram_ready) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
      ram_ready <= 1'b1;
    end else if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        merged = ram[mem_address];
        for (int b = 0; b < BE_W; b++)
          if (mem_byteenable[b]) merged[b*8 +: 8] = mem_writedata[b*8 +: 8];
        ram[mem_address] <= merged;
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  // Reference model state
  logic [DATA_W-1:0] shadow [DEPTH];
  int                exp_last = 1;
  bit                pend = 0;
  int                pend_m = 0;
  logic [DATA_W-1:0] pend_data = '0;
  bit                exp_init = 0;

  // Current stimulus: op 0 idle, 1 read, 2 write
  int                op0 = 0, op1 = 0;
  logic [ADDR_W-1:0] a0 = '0, a1 = '0;
  logic [BE_W-1:0]   be0 = '1, be1 = '1;
  logic [DATA_W-1:0] d0 = '0, d1 = '0;

  int checks = 0;
  int errors = 0;

  function automatic int exp_grant(int o0, int o1, bit allowed);
    if (!allowed) return -1;
    if (o0 != 0 && o1 != 0) return (exp_last == 1) ? 0 : 1;
    if (o0 != 0) return 0;
    if (o1 != 0) return 1;
    return -1;
  endfunction

  task automatic apply();
    m0_bus.read = (op0 == 1); m0_bus.write = (op0 == 2);
    m0_bus.address = a0; m0_bus.byteenable = be0; m0_bus.writedata = d0;
    m1_bus.read = (op1 == 1); m1_bus.write = (op1 == 2);
    m1_bus.address = a1; m1_bus.byteenable = be1; m1_bus.writedata = d1;
  endtask

  task automatic commit(int g);
    int op; logic [ADDR_W-1:0] a; logic [BE_W-1:0] be; logic [DATA_W-1:0] d;
    pend = 0;
    if (g >= 0) begin
      op = (g == 0) ? op0 : op1; a = (g == 0) ? a0 : a1;
      be = (g == 0) ? be0 : be1; d = (g == 0) ? d0 : d1;
      exp_last = g;
      if (op == 2) begin
        for (int b = 0; b < BE_W; b++) if (be[b]) shadow[a][b*8 +: 8] = d[b*8 +: 8];
      end else begin
        pend = 1; pend_m = g; pend_data = shadow[a];
      end
    end
  endtask

  task automatic advance();
    int g;
    g = exp_grant(op0, op1, exp_init && !reset_req && !reset);
    @(posedge clk); #1;
    commit(g);
  endtask

  task automatic do_reset(output int n);
    op0 = 0; op1 = 0; apply();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    exp_last = 1; pend = 0; exp_init = 0;
`ifdef NIOS_MEM_ARB_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
`endif
    n = 0;
    while (!init_done && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    exp_init = 1;
  endtask

  task automatic test_reset();
    int n;
    op0 = 0; op1 = 0; apply();
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (m0_bus.waitrequest !== 1'b1) begin errors++; $display("FAIL reset_wait0 got %b want 1", m0_bus.waitrequest); end
    checks++; if (m1_bus.waitrequest !== 1'b1) begin errors++; $display("FAIL reset_wait1 got %b want 1", m1_bus.waitrequest); end
    checks++; if ({m0_bus.readdatavalid, m1_bus.readdatavalid} !== 2'b00) begin errors++; $display("FAIL reset_rdv got %b want 00", {m0_bus.readdatavalid, m1_bus.readdatavalid}); end
    checks++; if ({mem_chipselect, mem_write} !== 2'b00) begin errors++; $display("FAIL reset_cs_wr got %b want 00", {mem_chipselect, mem_write}); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done got %b want 0", init_done); end
    do_reset(n);
    checks++; if (n != INIT_CYCLES) begin errors++; $display("FAIL init_done_latency got %0d want %0d", n, INIT_CYCLES); end
  endtask

  task automatic test_single_read();
    logic [DATA_W-1:0] pat;
    pat = {16{8'hA5}};
    op0 = 2; a0 = 5; be0 = '1; d0 = pat; op1 = 0; apply();
    @(negedge clk);
    checks++; if (m0_bus.waitrequest !== 1'b0) begin errors++; $display("FAIL single_wr_wait got %b want 0", m0_bus.waitrequest); end
    checks++; if ({mem_chipselect, mem_write, mem_address} !== {2'b11, 11'd5}) begin errors++; $display("FAIL single_wr_bus got %b/%b/%0d want 1/1/5", mem_chipselect, mem_write, mem_address); end
    advance();
    op0 = 1; apply();
    @(negedge clk);
    checks++; if (m0_bus.waitrequest !== 1'b0) begin errors++; $display("FAIL single_rd_wait got %b want 0", m0_bus.waitrequest); end
    checks++; if ({mem_chipselect, mem_write} !== 2'b10) begin errors++; $display("FAIL single_rd_bus got %b want 10", {mem_chipselect, mem_write}); end
    advance();
    op0 = 0; apply();
    @(negedge clk);
    checks++; if (m0_bus.readdatavalid !== 1'b1) begin errors++; $display("FAIL single_rdv0 got %b want 1", m0_bus.readdatavalid); end
    checks++; if (m0_bus.readdata !== pat) begin errors++; $display("FAIL single_data got %h want %h", m0_bus.readdata, pat); end
    checks++; if (m1_bus.readdatavalid !== 1'b0) begin errors++; $display("FAIL single_rdv1 got %b want 0", m1_bus.readdatavalid); end
    advance();
  endtask

  task automatic test_contention();
    int g, c0, c1;
    logic [DATA_W-1:0] exp_d;
    op0 = 0; op1 = 2; be1 = '1;
    a1 = 1; d1 = {$urandom, $urandom, $urandom, $urandom}; apply(); advance();
    a1 = 2; d1 = {$urandom, $urandom, $urandom, $urandom}; apply(); advance();
    c0 = 0; c1 = 0;
    op0 = 1; a0 = 1; op1 = 1; a1 = 2;
    for (int c = 0; c < 7; c++) begin
      if (c == 6) begin op0 = 0; op1 = 0; end
      apply();
      @(negedge clk);
      g = (c == 6) ? -1 : (c % 2);
      checks++; if (m0_bus.waitrequest !== (c < 6 && g != 0)) begin errors++; $display("FAIL cont_wait0 cyc %0d got %b", c, m0_bus.waitrequest); end
      checks++; if (m1_bus.waitrequest !== (c < 6 && g != 1)) begin errors++; $display("FAIL cont_wait1 cyc %0d got %b", c, m1_bus.waitrequest); end
      if (c > 0) begin
        checks++; if (m0_bus.readdatavalid !== ((c - 1) % 2 == 0)) begin errors++; $display("FAIL cont_rdv0 cyc %0d got %b", c, m0_bus.readdatavalid); end
        checks++; if (m1_bus.readdatavalid !== ((c - 1) % 2 == 1)) begin errors++; $display("FAIL cont_rdv1 cyc %0d got %b", c, m1_bus.readdatavalid); end
        exp_d = ((c - 1) % 2 == 0) ? shadow[1] : shadow[2];
        checks++; if (mem_readdata !== exp_d) begin errors++; $display("FAIL cont_data cyc %0d got %h want %h", c, mem_readdata, exp_d); end
      end
      if (m0_bus.readdatavalid === 1'b1) c0++;
      if (m1_bus.readdatavalid === 1'b1) c1++;
      advance();
    end
    checks++; if (c0 != 3 || c1 != 3) begin errors++; $display("FAIL cont_pulses got %0d/%0d want 3/3", c0, c1); end
  endtask

  task automatic test_byteenable();
    logic [DATA_W-1:0] exp_d;
    exp_d = 128'hFF;
    op0 = 0; op1 = 2; a1 = 7; be1 = 16'h0001; d1 = '1; apply(); advance();
    op1 = 1; be1 = '1; apply(); advance();
    op1 = 0; apply();
    @(negedge clk);
    checks++; if (m1_bus.readdatavalid !== 1'b1) begin errors++; $display("FAIL be_rdv got %b want 1", m1_bus.readdatavalid); end
    checks++; if (m1_bus.readdata !== exp_d) begin errors++; $display("FAIL be_data got %h want %h", m1_bus.readdata, exp_d); end
    advance();
  endtask

  task automatic test_reset_req();
    op0 = 2; a0 = 9; be0 = '1; d0 = {$urandom, $urandom, $urandom, $urandom}; op1 = 0;
    reset_req = 1; apply();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if ({mem_clken, m0_bus.waitrequest, mem_chipselect} !== 3'b010) begin errors++; $display("FAIL rreq_hold cyc %0d clken/wait/cs got %b want 010", c, {mem_clken, m0_bus.waitrequest, mem_chipselect}); end
      advance();
    end
    reset_req = 0;
    @(negedge clk);
    checks++; if ({mem_clken, m0_bus.waitrequest, mem_chipselect} !== 3'b101) begin errors++; $display("FAIL rreq_resume clken/wait/cs got %b want 101", {mem_clken, m0_bus.waitrequest, mem_chipselect}); end
    advance();
    op0 = 0; apply();
  endtask

  task automatic test_reset_mid_read();
    int n;
    op0 = 1; a0 = 5; op1 = 0; apply();
    @(negedge clk);
    checks++; if (m0_bus.waitrequest !== 1'b0) begin errors++; $display("FAIL mid_grant got %b want 0", m0_bus.waitrequest); end
    advance();
    op0 = 0; apply(); reset = 1;
    @(negedge clk);
    checks++; if ({m0_bus.readdatavalid, m1_bus.readdatavalid} !== 2'b00) begin errors++; $display("FAIL mid_rdv got %b want 00", {m0_bus.readdatavalid, m1_bus.readdatavalid}); end
    do_reset(n);
    op0 = 1; a0 = 1; op1 = 1; a1 = 2; apply();
    @(negedge clk);
    checks++; if ({m0_bus.waitrequest, m1_bus.waitrequest} !== 2'b01) begin errors++; $display("FAIL mid_first_win wait0/1 got %b want 01", {m0_bus.waitrequest, m1_bus.waitrequest}); end
    advance();
    op0 = 0; op1 = 0; apply();
    @(negedge clk);
    checks++; if (m0_bus.readdatavalid !== 1'b1 || m0_bus.readdata !== shadow[1]) begin errors++; $display("FAIL mid_after_read rdv %b data %h want 1 %h", m0_bus.readdatavalid, m0_bus.readdata, shadow[1]); end
    advance();
  endtask

  task automatic test_random();
    int g; bit al; logic [ADDR_W-1:0] ga; int gop;
    for (int c = 0; c < 400; c++) begin
      op0 = $urandom_range(0, 2); op1 = $urandom_range(0, 2);
      a0 = ADDR_W'($urandom_range(0, 15)); a1 = ADDR_W'($urandom_range(0, 15));
      be0 = BE_W'($urandom); be1 = BE_W'($urandom);
      d0 = {$urandom, $urandom, $urandom, $urandom}; d1 = {$urandom, $urandom, $urandom, $urandom};
      reset_req = pend ? 1'b0 : ($urandom_range(0, 7) == 0);
      apply();
      @(negedge clk);
      al = exp_init && !reset_req;
      g = exp_grant(op0, op1, al);
      ga = (g == 1) ? a1 : a0; gop = (g == 1) ? op1 : op0;
      checks++; if (m0_bus.waitrequest !== ((g != 0) && (op0 != 0 || !al))) begin errors++; $display("FAIL rnd_wait0 cyc %0d got %b", c, m0_bus.waitrequest); end
      checks++; if (m1_bus.waitrequest !== ((g != 1) && (op1 != 0 || !al))) begin errors++; $display("FAIL rnd_wait1 cyc %0d got %b", c, m1_bus.waitrequest); end
      checks++; if (mem_clken !== !reset_req) begin errors++; $display("FAIL rnd_clken cyc %0d got %b", c, mem_clken); end
      checks++; if (mem_chipselect !== (g >= 0) || mem_write !== (g >= 0 && gop == 2)) begin errors++; $display("FAIL rnd_cs_wr cyc %0d got %b%b grant %0d", c, mem_chipselect, mem_write, g); end
      if (g >= 0) begin
        checks++; if (mem_address !== ga) begin errors++; $display("FAIL rnd_addr cyc %0d got %0d want %0d", c, mem_address, ga); end
      end
      checks++; if (m0_bus.readdatavalid !== (pend && pend_m == 0) || m1_bus.readdatavalid !== (pend && pend_m == 1)) begin errors++; $display("FAIL rnd_rdv cyc %0d got %b%b", c, m0_bus.readdatavalid, m1_bus.readdatavalid); end
      if (pend) begin
        checks++; if (((pend_m == 0) ? m0_bus.readdata : m1_bus.readdata) !== pend_data) begin errors++; $display("FAIL rnd_data cyc %0d got %h want %h", c, mem_readdata, pend_data); end
      end
      advance();
    end
    op0 = 0; op1 = 0; reset_req = 0; apply(); advance();
  endtask

`ifdef NIOS_MEM_ARB_CLEAR_EN
  task automatic test_clear();
    int n, bad;
    op0 = 2; a0 = 11'd2047; be0 = '1; d0 = {4{32'hDEADBEEF}}; op1 = 0; apply(); advance();
    op0 = 0; apply();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    n = 0; bad = 0;
    while (!init_done && n < 3000) begin
      @(negedge clk);
      if (m0_bus.waitrequest !== 1'b1 || m1_bus.waitrequest !== 1'b1) bad++;
      @(posedge clk); #1; n++;
    end
    for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
    exp_last = 1; pend = 0; exp_init = 1;
    checks++; if (n != 2048) begin errors++; $display("FAIL clear_latency got %0d want 2048", n); end
    checks++; if (bad != 0) begin errors++; $display("FAIL clear_wait_held got %0d bad cycles want 0", bad); end
    op0 = 1; a0 = 11'd2047; apply(); advance();
    op0 = 0; apply();
    @(negedge clk);
    checks++; if (m0_bus.readdatavalid !== 1'b1 || m0_bus.readdata !== '0) begin errors++; $display("FAIL clear_data rdv %b data %h want 1 0", m0_bus.readdatavalid, m0_bus.readdata); end
    advance();
  endtask
`endif

  initial begin
    for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
    apply();
    test_reset();
    test_single_read();
    test_contention();
    test_byteenable();
    test_reset_req();
    test_reset_mid_read();
    test_random();
`ifdef NIOS_MEM_ARB_CLEAR_EN
    test_clear();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
